// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: multiplier FSM states and the counter
// width that the multiplier and the divider both use.
package arith_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIXUP} mult_state_t;

  localparam int counter_msb_pos = 7;
endpackage

// File: rtl/shift_add_multiplier_if.sv
// Command/result bundle for shift_add_multiplier. The master drives operands
// and the strobe; the slave returns the product and the handshake flags.
interface shift_add_multiplier_if #(parameter int args_width = 32);
  logic                  enable;
  logic                  unsgn_or_sgn;
  logic [args_width-1:0] a;
  logic [args_width-1:0] b;
  logic [args_width-1:0] prod_hi;
  logic [args_width-1:0] prod_lo;
  logic                  can_accept_cmd;
  logic                  data_ready;

  modport master (output enable, unsgn_or_sgn, a, b,
                  input  prod_hi, prod_lo, can_accept_cmd, data_ready);
  modport slave  (input  enable, unsgn_or_sgn, a, b,
                  output prod_hi, prod_lo, can_accept_cmd, data_ready);
endinterface

// File: rtl/mult_step.sv
// One shift-and-add step on the {carry, hi, lo} accumulator.
// lo[0] selects whether |a| is added into {carry, hi} before the right shift.
module mult_step #(parameter int args_width = 32) (
  input  logic                  carry,
  input  logic [args_width-1:0] hi,
  input  logic [args_width-1:0] lo,
  input  logic [args_width-1:0] a_mag,
  output logic                  nxt_carry,
  output logic [args_width-1:0] nxt_hi,
  output logic [args_width-1:0] nxt_lo
);
  logic [args_width:0] sum;

  always_comb begin
    sum = {carry, hi} + (lo[0] ? {1'b0, a_mag} : '0);
  end

  // After the shift the add carry lands in hi's MSB, so the carry slot empties.
  assign nxt_carry = 1'b0;
  assign nxt_hi    = sum[args_width:1];
  assign nxt_lo    = {sum[0], lo[args_width-1:1]};
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential signed/unsigned shift-and-add multiplier (IDLE -> RUN -> FIXUP).
// Define MULT_TWO_BITS_PER_CYCLE_EN to retire two multiplier bits per RUN cycle.
module shift_add_multiplier
  import arith_pkg::*;
#(parameter int args_width = 32) (
  input  logic                    clk,
  input  logic                    rst_n,
  shift_add_multiplier_if.slave   bus
);
  localparam int CNT_W = counter_msb_pos + 1;
`ifdef MULT_TWO_BITS_PER_CYCLE_EN
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(args_width / 2);
  if (args_width % 2 != 0) begin : g_odd_width
    $error("shift_add_multiplier: args_width must be even for two bits per cycle");
  end
`else
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(args_width);
`endif

  mult_state_t             state;
  logic [CNT_W-1:0]        cnt;
  logic                    neg;
  logic                    carry;
  logic [args_width-1:0]   a_mag, hi, lo;
  logic [args_width-1:0]   prod_hi_q, prod_lo_q;
  logic                    can_accept_q, data_ready_q;
  logic [args_width-1:0]   a_abs, b_abs;
  logic [2*args_width-1:0] product;
  logic                    st_c;
  logic [args_width-1:0]   st_h, st_l;

  always_comb begin
    a_abs   = (bus.unsgn_or_sgn && bus.a[args_width-1]) ? -bus.a : bus.a;
    b_abs   = (bus.unsgn_or_sgn && bus.b[args_width-1]) ? -bus.b : bus.b;
    product = neg ? -{hi, lo} : {hi, lo};
  end

`ifdef MULT_TWO_BITS_PER_CYCLE_EN
  logic                  mid_c;
  logic [args_width-1:0] mid_h, mid_l;

  mult_step #(.args_width(args_width)) u_step0 (
    .carry(carry), .hi(hi), .lo(lo), .a_mag(a_mag),
    .nxt_carry(mid_c), .nxt_hi(mid_h), .nxt_lo(mid_l));
  mult_step #(.args_width(args_width)) u_step1 (
    .carry(mid_c), .hi(mid_h), .lo(mid_l), .a_mag(a_mag),
    .nxt_carry(st_c), .nxt_hi(st_h), .nxt_lo(st_l));
`else
  mult_step #(.args_width(args_width)) u_step0 (
    .carry(carry), .hi(hi), .lo(lo), .a_mag(a_mag),
    .nxt_carry(st_c), .nxt_hi(st_h), .nxt_lo(st_l));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      neg          <= 1'b0;
      carry        <= 1'b0;
      a_mag        <= '0;
      hi           <= '0;
      lo           <= '0;
      prod_hi_q    <= '0;
      prod_lo_q    <= '0;
      can_accept_q <= 1'b1;
      data_ready_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.enable) begin
          a_mag        <= a_abs;
          lo           <= b_abs;
          hi           <= '0;
          carry        <= 1'b0;
          neg          <= bus.unsgn_or_sgn & (bus.a[args_width-1] ^ bus.b[args_width-1]);
          cnt          <= CNT_LOAD;
          can_accept_q <= 1'b0;
          data_ready_q <= 1'b0;
          state        <= RUN;
        end
        RUN: begin
          carry <= st_c;
          hi    <= st_h;
          lo    <= st_l;
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FIXUP;
        end
        FIXUP: begin
          {prod_hi_q, prod_lo_q} <= product;
          data_ready_q           <= 1'b1;
          can_accept_q           <= 1'b1;
          state                  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.prod_hi        = prod_hi_q;
  assign bus.prod_lo        = prod_lo_q;
  assign bus.can_accept_cmd = can_accept_q;
  assign bus.data_ready     = data_ready_q;
endmodule
